// File: rtl/key_operand_loader.sv
// Two-key operand entry: debounced LOAD/CLEAR latch sw into a then b.
// Define LOADER_DEBOUNCE_EN for the counting debouncer; otherwise keys pass straight through.
module key_operand_loader #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       key_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        READY = 2'b10,
        BAD   = 2'b11
    } st_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] press;
    logic       ld;
    logic       clr;
    st_t        st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count [2];
    logic [1:0]    flip;

    always_comb begin
        flip = 2'b00;
        for (int k = 0; k < 2; k++) begin
            flip[k] = (sync2[k] != stable[k]) && (count[k] == LAST);
        end
    end

    // a flip while stable is high can only be a press
    assign press = flip & stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == stable[k]) begin
                    count[k] <= '0;
                end else if (flip[k]) begin
                    stable[k] <= sync2[k];
                    count[k]  <= '0;
                end else begin
                    count[k] <= count[k] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 2'b11;
        end else begin
            stable <= sync2;
        end
    end

    assign press = stable & ~sync2;
`endif

    assign ld  = press[0];
    assign clr = press[1];

    // CLEAR outranks LOAD when both strobe on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            valid <= 1'b0;
            st    <= IDLE;
        end else if (clr) begin
            a     <= '0;
            b     <= '0;
            valid <= 1'b0;
            st    <= IDLE;
        end else begin
            case (st)
                IDLE: begin
                    if (ld) begin
                        a  <= sw;
                        st <= GOT_A;
                    end
                end
                GOT_A: begin
                    if (ld) begin
                        b     <= sw;
                        valid <= 1'b1;
                        st    <= READY;
                    end
                end
                READY: begin
                    if (ld) begin
                        a     <= sw;
                        b     <= '0;
                        valid <= 1'b0;
                        st    <= GOT_A;
                    end
                end
                default: begin
                    a     <= '0;
                    b     <= '0;
                    valid <= 1'b0;
                    st    <= IDLE;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: doc/key_operand_loader.md
# key_operand_loader

Operand-entry front end for the 5-bit adder demo board. It debounces the two push buttons and latches the slide-switch value as operand A, then as operand B, in sequence. It presents both operands with a valid flag to the adder stage, so A and B no longer need to share the 10 switches and can each use the full switch field.

## Interface

Parameters:
- WIDTH, 5, operand width; also the number of switch inputs used
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 1

Ports:
- clk  input  1  single system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- key_n  input  2  raw push buttons, active-low; key_n[0] = LOAD, key_n[1] = CLEAR
- sw  input  WIDTH  raw switch value, sampled only on a LOAD event
- a  output  WIDTH  latched operand A
- b  output  WIDTH  latched operand B
- valid  output  1  high when both a and b hold freshly entered operands
- state  output  2  FSM encoding for LEDs: 00 IDLE, 01 GOT_A, 10 READY

## Operation

- Per key, independently:
  - Two-flop synchronizer (sync1, sync2), then a debouncer holding `stable` and a counter.
  - Counter resets to 0 whenever sync2 == stable; otherwise it increments.
  - When sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Press event: a one-cycle internal strobe, true in the cycle in which stable flips 1 -> 0. Release (0 -> 1) generates no event.
- FSM, acting at the edge where the strobe is true:
  - IDLE + LOAD: a <= sw; -> GOT_A.
  - GOT_A + LOAD: b <= sw; valid <= 1; -> READY.
  - READY + LOAD: a <= sw; b <= 0; valid <= 0; -> GOT_A (starts a new entry).
  - Any state + CLEAR: a <= 0; b <= 0; valid <= 0; -> IDLE.
  - LOAD and CLEAR strobes on the same edge: CLEAR wins, and LOAD is discarded.
  - Encoding 11 is unreachable; if it is ever entered, the FSM goes to IDLE on the next edge.
- sw is used unsynchronized only at the LOAD edge. Switches are assumed static while a key is pressed; a change coinciding with that edge may latch either value.
- Holding a key generates exactly one event, with no auto-repeat.

## Timing

- Reset (rst_n low, asynchronous): a = 0, b = 0, valid = 0, state = 00. sync1/sync2/stable = 1 (released), counters = 0. All outputs are at these values while rst_n is low.
- Press latency: with key_n held low, the first rising edge that samples it low is edge 1. The outputs update at edge DEBOUNCE_CYCLES+2.
- Bounce: any return of sync2 to the stable level before the count completes resets the counter. The full DEBOUNCE_CYCLES window restarts.
- Release is filtered identically. A new press is accepted only after stable has returned to 1.
- Minimum key-to-key spacing for two distinct events: press, release and press must each be held for at least DEBOUNCE_CYCLES cycles.
- Reset mid-debounce or mid-entry: all progress is discarded. A key held low through reset release counts as a fresh press, with latency measured from the first edge after deassertion.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration

- LOADER_DEBOUNCE_EN defined: debouncer as specified above.
- LOADER_DEBOUNCE_EN undefined:
  - The counter logic is removed and stable <= sync2 on every edge.
  - The strobe is stable == 1 && sync2 == 0.
  - Press latency becomes 3 edges. DEBOUNCE_CYCLES is ignored.
  - For fast simulation and glitch-free stimulus only.

## Test plan

Run with DEBOUNCE_CYCLES = 4 and LOADER_DEBOUNCE_EN defined unless stated.

- Reset then idle: rst_n low for 3 cycles, then high -> a=0, b=0, valid=0, state=00; holds indefinitely with keys released.
- Entry sequence:
  - sw=5'h13, LOAD held 10 cycles -> a=0x13, state=01 on edge 6 after first low sample.
  - Release, then sw=5'h0A, LOAD held again -> b=0x0A, valid=1, state=10.
- Bounce rejection: LOAD low 3 cycles, high 1, low 3, high -> no output change; then low 6 cycles -> single event.
- READY + LOAD with sw=5'h1F -> a=0x1F, b=0, valid=0, state=01.
- CLEAR and LOAD pressed on the same cycle from GOT_A -> a=0, b=0, valid=0, state=00.
- Mid-entry reset:
  - In GOT_A, pulse rst_n low during a LOAD debounce count -> all outputs 0 immediately.
  - With LOAD still held after reset release -> a=sw at edge 6.
- Macro undefined -> the same entry sequence updates at edge 3.
